// File: rtl/divider_pkg.sv
// Shared types and defaults for the divider sequencer and its counter.
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } div_state_e;

  localparam int unsigned DefaultResetDiv = 1;

endpackage

// File: rtl/div_counter.sv
// Free-running counter with terminal-count compare against a programmable limit.
module div_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == limit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/divider_sequencer.sv
// Run/stop sequencer for the divider: ticks every active_q+1 cycles, toggles Q on each
// tick and swaps in a pending ratio only at terminal count so Q never glitches.
module divider_sequencer
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_DIV = DefaultResetDiv
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             Q,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  div_state_e       state_q;
  logic             busy_q;
  logic             toggle_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] pend_q;
  logic             pend_valid_q;
  logic             tc;
  logic             cfg_xfer;

  div_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (busy_q),
    .clr    (~busy_q),
    .limit  (active_q),
    .count  (count),
    .tc     (tc)
  );

  assign tick      = busy_q & tc;
  assign cfg_xfer  = cfg_valid & cfg_ready;
  assign cfg_ready = ~pend_valid_q;
  assign Q         = toggle_q;
  assign busy      = busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      toggle_q     <= 1'b0;
      active_q     <= WIDTH'(RESET_DIV);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (stop) state_q <= StStopping;
        end
        StStopping: begin
          // Only the falling toggle ends the stop, so the last high phase is complete.
          if (tick && toggle_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase

      if (tick) toggle_q <= ~toggle_q;

      // A transfer implies an empty slot, so it never collides with a slot drain.
      if (cfg_xfer) begin
        if (!busy_q) begin
          active_q <= cfg_div;
        end else begin
          pend_q       <= cfg_div;
          pend_valid_q <= 1'b1;
        end
      end else if (pend_valid_q && (!busy_q || tick)) begin
        active_q     <= pend_q;
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Bench for divider_sequencer: fixed vector table, corner-case sequences and random
// stimulus compared every cycle against a behavioural model.
module tb_divider_sequencer;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         tick;
  logic         Q;
  logic         busy;
  logic [W-1:0] count;

  divider_sequencer #(
    .WIDTH    (W),
    .RESET_DIV(1)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .tick     (tick),
    .Q        (Q),
    .busy     (busy),
    .count    (count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: running/stopping flags, a cycle position, and a pending queue.
  bit m_run;
  bit m_stopping;
  bit m_q;
  int m_cnt;
  int m_act;
  int m_pend[$];

  function automatic void m_reset();
    m_run = 0;
    m_stopping = 0;
    m_q = 0;
    m_cnt = 0;
    m_act = 1;
    m_pend.delete();
  endfunction

  function automatic bit m_tick();
    return m_run && (m_cnt == m_act);
  endfunction

  function automatic void m_step(bit s, bit p, bit v, int d);
    bit t;
    bit was_run;
    bit rdy;
    t = m_tick();
    was_run = m_run;
    rdy = (m_pend.size() == 0);
    if (!m_run) begin
      if (s && !p) begin
        m_run = 1;
        m_stopping = 0;
      end
    end else begin
      if (t) begin
        m_q = !m_q;
        m_cnt = 0;
        if (m_stopping && !m_q) m_run = 0;
      end else begin
        m_cnt++;
      end
      if (p) m_stopping = 1;
    end
    if (v && rdy) begin
      if (!was_run) m_act = d;
      else m_pend.push_back(d);
    end else if (m_pend.size() > 0 && (!was_run || t)) begin
      m_act = m_pend.pop_front();
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("count", count, m_cnt);
    chk("Q", Q, m_q);
    chk("tick", tick, m_tick());
    chk("busy", busy, m_run);
    chk("cfg_ready", cfg_ready, m_pend.size() == 0);
  endtask

  // Drive inputs just after an edge, let the next edge act, then compare.
  task automatic cyc(input bit s, input bit p, input bit v, input logic [W-1:0] d);
    start = s;
    stop = p;
    cfg_valid = v;
    cfg_div = d;
    @(posedge clock);
    m_step(s, p, v, d);
    #1;
    chk_model();
  endtask

  // Reset asserted between edges so the clearing must be asynchronous.
  task automatic hard_reset();
    start = 0;
    stop = 0;
    cfg_valid = 0;
    cfg_div = '0;
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk_model();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    m_step(0, 0, 0, 0);
    #1;
    chk_model();
  endtask

  task automatic stop_to_idle(input int bound);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < bound && busy; i++) cyc(0, 0, 0, 0);
    chk("stop_reaches_idle", busy, 0);
  endtask

  typedef struct {
    bit s, p, v;
    logic [7:0] d;
    bit t, q, b;
    logic [7:0] c;
    bit r;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int hi;
    int n;
    int last;
    bit was_rdy;

    tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 1, 0, 1, 1, 1};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[5]  = '{0, 0, 1, 4, 1, 0, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 2, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 1, 3, 1};
    tbl[10] = '{0, 0, 0, 0, 1, 1, 1, 4, 1};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 2, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 3, 1};
    tbl[15] = '{0, 0, 0, 0, 1, 0, 1, 4, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    tbl[17] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    tbl[18] = '{0, 0, 0, 0, 0, 1, 1, 2, 1};
    tbl[19] = '{0, 0, 0, 0, 0, 1, 1, 3, 1};
    tbl[20] = '{0, 0, 0, 0, 1, 1, 1, 4, 1};
    tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[22] = '{1, 1, 0, 0, 0, 0, 0, 0, 1};

    // Power-on reset
    m_reset();
    #3;
    chk_model();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    m_step(0, 0, 0, 0);
    #1;
    chk_model();

    // Vector table: ratio 1 run, ratio change to 4 mid-run, clean stop, start+stop in IDLE
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d.tick", i), tick, tbl[i].t);
      chk($sformatf("vec%0d.Q", i), Q, tbl[i].q);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].b);
      chk($sformatf("vec%0d.count", i), count, tbl[i].c);
      chk($sformatf("vec%0d.cfg_ready", i), cfg_ready, tbl[i].r);
    end

    // Ratio 4 accepted in IDLE, first tick four cycles after the count=0 cycle
    cyc(0, 0, 1, 4);
    cyc(1, 0, 0, 0);
    n = 0;
    while (!tick && n < 20) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("first_tick_ratio4", n, 4);
    repeat (12) cyc(0, 0, 0, 0);
    stop_to_idle(40);

    // Ratio 3 running, offer 0 then 7 back-to-back
    cyc(0, 0, 1, 3);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("ratio0_pending_ready", cfg_ready, 0);
    for (int i = 0; i < 10; i++) begin
      was_rdy = cfg_ready;
      cyc(0, 0, 1, 7);
      if (was_rdy) break;
    end
    chk("ratio7_pending_ready", cfg_ready, 0);
    repeat (20) cyc(0, 0, 0, 0);
    stop_to_idle(40);

    // Ratio 2, stop while Q low, start held through STOPPING must not restart
    cyc(0, 0, 1, 2);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    hi = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      cyc(1, 0, 0, 0);
      if (Q) hi++;
    end
    chk("stop_high_phase", hi, 3);
    chk("stop_idle_busy", busy, 0);
    cyc(0, 0, 0, 0);

    // Mid-run reset discards a pending ratio
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 9);
    hard_reset();
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    stop_to_idle(20);

    // Full-range ratio 255: 256-cycle tick spacing and wrap to 0
    cyc(0, 0, 1, 255);
    cyc(1, 0, 0, 0);
    last = -1;
    for (int i = 0; i < 800; i++) begin
      cyc(0, 0, 0, 0);
      if (tick) begin
        if (last >= 0) chk("tick_interval_255", i - last, 256);
        last = i;
      end
    end
    chk("saw_tick_255", last >= 0, 1);
    stop_to_idle(600);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        hard_reset();
      end else begin
        cyc($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(2) == 0,
            ($urandom_range(9) == 0) ? W'($urandom_range(255)) : W'($urandom_range(7)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
